// File: rtl/sram_mem_arbiter.sv
// Arbitrates the 16-bit board SRAM between instruction fetch and MEM-stage data accesses.
// Each 32-bit word is moved as a low half then a high half, each held for WAIT_STATES cycles.
module sram_mem_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_STATES = 2,
  parameter int DATA_BASE   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [15:0]       sram_dq_in,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_mem_q, owner_mem_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-2:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [31:0] data_eff;
  logic        mem_req;
  logic        last_cycle;

  assign data_eff   = mem_addr - 32'(DATA_BASE);
  assign mem_req    = mem_rd | mem_wr;
  assign last_cycle = (cnt_q == LAST_CNT);

  // Byte-lane and upper address bits outside the SRAM window are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+1], if_addr[1:0],
                              data_eff[31:ADDR_W+1], data_eff[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      owner_mem_q <= 1'b0;
      wr_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_mem_q <= owner_mem_d;
      wr_q        <= wr_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_mem_d = owner_mem_q;
    wr_d        = wr_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready    = 1'b0;
    mem_ready   = 1'b0;
    sram_addr   = '0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        // Data port wins; a simultaneous rd+wr is a write.
        if (mem_req) begin
          owner_mem_d = 1'b1;
          wr_d        = mem_wr;
          base_d      = data_eff[ADDR_W:2];
          wdata_d     = mem_wdata;
          state_d     = LO;
        end else if (if_req) begin
          owner_mem_d = 1'b0;
          wr_d        = 1'b0;
          base_d      = if_addr[ADDR_W:2];
          state_d     = LO;
        end
      end

      LO: begin
        sram_addr = {base_q, 1'b0};
        if (wr_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (last_cycle) begin
          cnt_d   = 3'd0;
          state_d = HI;
          if (!wr_q) begin
            if (owner_mem_q) mem_rdata_d = {mem_rdata_q[31:16], sram_dq_in};
            else             if_rdata_d  = {if_rdata_q[31:16], sram_dq_in};
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      HI: begin
        sram_addr = {base_q, 1'b1};
        if (wr_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (last_cycle) begin
          cnt_d   = 3'd0;
          state_d = DONE;
          if (!wr_q) begin
            if (owner_mem_q) mem_rdata_d = {sram_dq_in, mem_rdata_q[15:0]};
            else             if_rdata_d  = {sram_dq_in, if_rdata_q[15:0]};
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      DONE: begin
        if_ready  = ~owner_mem_q;
        mem_ready = owner_mem_q;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: doc/sram_mem_arbiter.md
Name: sram_mem_arbiter

Overview:
- Shares the single-port 16-bit board SRAM between the ARM pipeline's instruction-fetch port and MEM-stage data port.
- Each 32-bit word access becomes two 16-bit SRAM accesses (low half, then high half), each lasting WAIT_STATES cycles.
- Returns a one-cycle ready pulse to the winning requester. The pipeline freezes on the requester's ready being low.
- Sits between the pipeline stages and the SRAM pins inside ARM_Module.

Parameters:
- ADDR_W, 18, SRAM word-address width (sram_addr width).
- WAIT_STATES, 2, cycles per 16-bit SRAM access; legal range 1..7.
- DATA_BASE, 1024, byte offset subtracted from mem_addr before mapping to SRAM.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  instruction-fetch request.
- if_addr  in  32  fetch byte address, word aligned.
- if_rdata  out  32  fetched word, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- mem_rd  in  1  data read request.
- mem_wr  in  1  data write request.
- mem_addr  in  32  data byte address, word aligned.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read word, valid while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for data access.
- sram_addr  out  ADDR_W  SRAM half-word address.
- sram_dq_in  in  16  SRAM read bus.
- sram_dq_out  out  16  SRAM write bus.
- sram_dq_oe  out  1  drive enable for the SRAM data bus (1 = drive).
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- FSM states: IDLE, LO, HI, DONE. The wait counter is 3 bits.
- IDLE:
  - Samples requests each cycle.
  - Data port has priority: (mem_rd|mem_wr) is granted over if_req.
  - On grant, latches owner, op, address and wdata; goes to LO with counter=0.
  - With no request, stays in IDLE.
- LO:
  - sram_addr = {eff_addr[ADDR_W:2], 1'b0}.
  - eff_addr = mem_addr-DATA_BASE for the data port, if_addr for the fetch port.
  - Stays for WAIT_STATES cycles. In the final cycle, read ops capture sram_dq_in into rdata[15:0].
  - Then goes to HI with counter reset.
- HI:
  - Same as LO, with address LSB=1 and capture into rdata[31:16].
  - Then goes to DONE.
- Write ops:
  - sram_dq_oe=1 and sram_we_n=0 for every LO/HI cycle.
  - sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
  - Read ops and fetches keep sram_we_n=1 and sram_dq_oe=0.
- DONE:
  - Owner's ready=1 for exactly one cycle, with rdata held. The other ready stays 0.
  - Goes to IDLE; SRAM strobes are inactive.
  - rdata outputs hold their value until the next capture.
- Latency:
  - Accept edge, then WAIT_STATES cycles in LO, WAIT_STATES cycles in HI, then 1 DONE cycle.
  - Ready is high in cycle 2*WAIT_STATES+1 after acceptance.
  - Back-to-back accesses are separated by at least one IDLE cycle.
- No preemption: a data request arriving mid-fetch waits until the fetch's DONE, then wins in IDLE.
- Requester contract: the request is held until ready. A request dropped mid-access still completes and pulses ready; the pulse is ignored.
- mem_rd and mem_wr asserted together: treated as a write.
- Address latching: address and wdata are latched at grant; later input changes do not affect the access in flight.
- Reset mid-access: immediate abort with no ready pulse. sram_we_n returns to 1 asynchronously. The partial write is not retried.

Test Plan:
- Fetch read, WAIT_STATES=2, if_addr=0x8:
  - SRAM returns 0x5678 at addr 4 and 0x1234 at addr 5.
  - Required: if_ready pulses exactly in cycle 5 after acceptance, if_rdata=0x12345678, sram_we_n stays 1.
- Data write, mem_addr=1024+4, mem_wdata=0xDEADBEEF:
  - Required: sram_addr 2 with dq_out=0xBEEF for 2 cycles, then 3 with 0xDEAD.
  - we_n=0 and oe=1 in those 4 cycles; mem_ready pulse in cycle 5.
- Simultaneous if_req and mem_rd in IDLE:
  - Required: data served first; fetch accepted on the IDLE cycle after DONE; if_ready 6 cycles after mem_ready.
- mem_rd asserted during fetch LO:
  - Required: fetch completes unchanged (if_ready first), then data read runs; no strobe glitch between accesses.
- rst_n pulled low in the HI state of a write:
  - Required: sram_we_n=1 and oe=0 within the same cycle, no mem_ready, FSM in IDLE after release.
- WAIT_STATES=1 regression, read then write back-to-back on the data port:
  - Required: ready pulses 3 cycles after each acceptance, with one IDLE cycle between accesses.
